// File: rtl/uart_key_decoder.sv
// uart_key_decoder
//   Turns bytes from a UART receiver into one-cycle key pulses for a game
//   controller. Plain keys (WASD, Enter, Space) are decoded in one byte.
//   ANSI arrow keys (ESC '[' A/B/C/D) are decoded through a three-state FSM.
//   An escape sequence is abandoned without error if the gap between its
//   bytes exceeds TIMEOUT_CYCLES.
//
// Ports
//   clk        system clock (UART clock domain)
//   reset      asynchronous, active-low reset
//   rx_data    received byte, sampled only while rx_valid is high
//   rx_valid   one-cycle strobe qualifying rx_data
//   up, down, left, right, enter, space
//              one-cycle key pulses; at most one is high in any cycle
//   key_valid  high in the same cycle as any key pulse
//   key_code   0 none, 1 up, 2 down, 3 left, 4 right, 5 enter, 6 space;
//              holds its value until the next key_valid
//   seq_error  one-cycle pulse when an escape sequence is malformed
module uart_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       enter,
  output logic       space,
  output logic       key_valid,
  output logic [2:0] key_code,
  output logic       seq_error
);

  typedef enum logic [1:0] {
    IDLE,
    ESC,
    CSI
  } state_t;

  localparam logic [2:0] K_NONE  = 3'd0;
  localparam logic [2:0] K_UP    = 3'd1;
  localparam logic [2:0] K_DOWN  = 3'd2;
  localparam logic [2:0] K_LEFT  = 3'd3;
  localparam logic [2:0] K_RIGHT = 3'd4;
  localparam logic [2:0] K_ENTER = 3'd5;
  localparam logic [2:0] K_SPACE = 3'd6;

  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);

  state_t      state, state_n;
  logic [23:0] cnt, cnt_n;
  logic [2:0]  key_n;
  logic        err_n;

  // Next state, next counter value and the key/error to be registered.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    key_n   = K_NONE;
    err_n   = 1'b0;

    case (state)
      IDLE: begin
        // Holding the counter at zero in IDLE gives the clear-on-entry.
        cnt_n = '0;
        if (rx_valid) begin
          case (rx_data)
            8'h77, 8'h57: key_n = K_UP;
            8'h73, 8'h53: key_n = K_DOWN;
            8'h61, 8'h41: key_n = K_LEFT;
            8'h64, 8'h44: key_n = K_RIGHT;
            8'h0D, 8'h0A: key_n = K_ENTER;
            8'h20:        key_n = K_SPACE;
            8'h1B:        state_n = ESC;
            default:      ;
          endcase
        end
      end

      ESC: begin
        // A byte arriving in the timeout cycle still takes priority.
        if (rx_valid) begin
          cnt_n = '0;
          if (rx_data == 8'h5B) begin
            state_n = CSI;
          end else begin
            state_n = IDLE;
            err_n   = 1'b1;
          end
        end else if (cnt == TO_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt != '1) begin
          cnt_n = cnt + 24'd1;
        end
      end

      CSI: begin
        if (rx_valid) begin
          cnt_n   = '0;
          state_n = IDLE;
          case (rx_data)
            8'h41:   key_n = K_UP;
            8'h42:   key_n = K_DOWN;
            8'h43:   key_n = K_RIGHT;
            8'h44:   key_n = K_LEFT;
            default: err_n = 1'b1;
          endcase
        end else if (cnt == TO_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt != '1) begin
          cnt_n = cnt + 24'd1;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      up        <= 1'b0;
      down      <= 1'b0;
      left      <= 1'b0;
      right     <= 1'b0;
      enter     <= 1'b0;
      space     <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= K_NONE;
      seq_error <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      up        <= (key_n == K_UP);
      down      <= (key_n == K_DOWN);
      left      <= (key_n == K_LEFT);
      right     <= (key_n == K_RIGHT);
      enter     <= (key_n == K_ENTER);
      space     <= (key_n == K_SPACE);
      key_valid <= (key_n != K_NONE);
      if (key_n != K_NONE) begin
        key_code <= key_n;
      end
      seq_error <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_key_decoder.sv
// Bench for uart_key_decoder. Two instances share the same byte stream:
// dut_a keeps the default (long) timeout, dut_b uses TIMEOUT_CYCLES=16 so
// the timeout path and its boundary can be exercised in few cycles.
// Observed outputs are packed as {up,down,left,right,enter,space,
// key_valid,key_code[2:0],seq_error}.
module tb_uart_key_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  logic       up_a, down_a, left_a, right_a, enter_a, space_a, kv_a, err_a;
  logic [2:0] code_a;
  logic       up_b, down_b, left_b, right_b, enter_b, space_b, kv_b, err_b;
  logic [2:0] code_b;

  always #5 clk = ~clk;

  uart_key_decoder dut_a (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .up(up_a), .down(down_a), .left(left_a), .right(right_a),
    .enter(enter_a), .space(space_a), .key_valid(kv_a),
    .key_code(code_a), .seq_error(err_a)
  );

  uart_key_decoder #(.TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .up(up_b), .down(down_b), .left(left_b), .right(right_b),
    .enter(enter_b), .space(space_b), .key_valid(kv_b),
    .key_code(code_b), .seq_error(err_b)
  );

  logic [11:0] out_a, out_b;
  assign out_a = {up_a, down_a, left_a, right_a, enter_a, space_a, kv_a, code_a, err_a};
  assign out_b = {up_b, down_b, left_b, right_b, enter_b, space_b, kv_b, code_b, err_b};

  localparam logic [5:0] P_NO = 6'b000000;
  localparam logic [5:0] P_UP = 6'b100000;
  localparam logic [5:0] P_DN = 6'b010000;
  localparam logic [5:0] P_LF = 6'b001000;
  localparam logic [5:0] P_RT = 6'b000100;
  localparam logic [5:0] P_EN = 6'b000010;
  localparam logic [5:0] P_SP = 6'b000001;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [5:0] p;
    logic [2:0] c;
    logic       e;
  } vec_t;

  vec_t tbl[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  function automatic logic [11:0] ex(input logic [5:0] p, input logic [2:0] c, input logic e);
    return {p, |p, c, e};
  endfunction

  task automatic add(input logic v, input logic [7:0] d, input logic [5:0] p,
                     input logic [2:0] c, input logic e);
    vec_t t;
    t.v = v; t.d = d; t.p = p; t.c = c; t.e = e;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %03h expected %03h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge, when the outputs
  // reflect the byte sampled on the edge in between.
  task automatic send(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(negedge clk);
  endtask

  task automatic idle_chk(input int unsigned n, input string nm,
                          input logic [11:0] ea, input logic [11:0] eb);
    for (int unsigned i = 0; i < n; i++) begin
      send(1'b0, 8'h00);
      chk({nm, "_a"}, out_a, ea);
      chk({nm, "_b"}, out_b, eb);
    end
  endtask

  initial begin
    // Outputs are held clear by reset before any clock edge.
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    #3;
    chk("reset_a", out_a, '0);
    chk("reset_b", out_b, '0);
    @(negedge clk);
    chk("reset_clk_a", out_a, '0);
    chk("reset_clk_b", out_b, '0);
    reset = 1'b1;

    // Plain keys, back-to-back, then escape sequences; both instances agree
    // because no gap gets near either timeout.
    add(1, 8'h77, P_UP, 3'd1, 0);
    add(1, 8'h41, P_LF, 3'd3, 0);
    add(1, 8'h0D, P_EN, 3'd5, 0);
    add(1, 8'h20, P_SP, 3'd6, 0);
    add(1, 8'h57, P_UP, 3'd1, 0);
    add(1, 8'h53, P_DN, 3'd2, 0);
    add(1, 8'h73, P_DN, 3'd2, 0);
    add(1, 8'h61, P_LF, 3'd3, 0);
    add(1, 8'h44, P_RT, 3'd4, 0);
    add(1, 8'h64, P_RT, 3'd4, 0);
    add(1, 8'h0A, P_EN, 3'd5, 0);
    add(0, 8'h77, P_NO, 3'd5, 0);
    add(1, 8'h30, P_NO, 3'd5, 0);
    add(1, 8'h1B, P_NO, 3'd5, 0);
    add(0, 8'h41, P_NO, 3'd5, 0);
    add(1, 8'h5B, P_NO, 3'd5, 0);
    add(1, 8'h41, P_UP, 3'd1, 0);
    add(1, 8'h1B, P_NO, 3'd1, 0);
    add(1, 8'h5B, P_NO, 3'd1, 0);
    add(1, 8'h42, P_DN, 3'd2, 0);
    add(1, 8'h1B, P_NO, 3'd2, 0);
    add(1, 8'h5B, P_NO, 3'd2, 0);
    add(1, 8'h43, P_RT, 3'd4, 0);
    add(1, 8'h1B, P_NO, 3'd4, 0);
    add(1, 8'h5B, P_NO, 3'd4, 0);
    add(1, 8'h44, P_LF, 3'd3, 0);
    add(1, 8'h1B, P_NO, 3'd3, 0);
    add(1, 8'h5B, P_NO, 3'd3, 0);
    add(1, 8'h5A, P_NO, 3'd3, 1);
    add(1, 8'h1B, P_NO, 3'd3, 0);
    add(1, 8'h41, P_NO, 3'd3, 1);
    add(1, 8'h1B, P_NO, 3'd3, 0);
    add(0, 8'h00, P_NO, 3'd3, 0);
    add(0, 8'h00, P_NO, 3'd3, 0);
    add(0, 8'h00, P_NO, 3'd3, 0);
    add(1, 8'h5B, P_NO, 3'd3, 0);
    add(1, 8'h20, P_NO, 3'd3, 1);
    add(1, 8'h77, P_UP, 3'd1, 0);
    add(1, 8'h5B, P_NO, 3'd1, 0);
    add(1, 8'h1B, P_NO, 3'd1, 0);
    add(1, 8'h1B, P_NO, 3'd1, 1);
    add(1, 8'h44, P_RT, 3'd4, 0);

    foreach (tbl[i]) begin
      send(tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d_a", i), out_a, ex(tbl[i].p, tbl[i].c, tbl[i].e));
      chk($sformatf("vec%0d_b", i), out_b, ex(tbl[i].p, tbl[i].c, tbl[i].e));
    end

    // Arrow with 100-cycle gaps: long timeout decodes right; the short
    // timeout drops ESC silently and ignores '[' and 'C' in IDLE.
    send(1'b1, 8'h1B);
    chk("gap_esc_a", out_a, ex(P_NO, 3'd4, 0));
    chk("gap_esc_b", out_b, ex(P_NO, 3'd4, 0));
    idle_chk(100, "gap1", ex(P_NO, 3'd4, 0), ex(P_NO, 3'd4, 0));
    send(1'b1, 8'h5B);
    chk("gap_csi_a", out_a, ex(P_NO, 3'd4, 0));
    chk("gap_csi_b", out_b, ex(P_NO, 3'd4, 0));
    idle_chk(100, "gap2", ex(P_NO, 3'd4, 0), ex(P_NO, 3'd4, 0));
    send(1'b1, 8'h43);
    chk("gap_c_a", out_a, ex(P_RT, 3'd4, 0));
    chk("gap_c_b", out_b, ex(P_NO, 3'd4, 0));

    // ESC, 20 idle, 'A': timed-out instance decodes left from IDLE.
    send(1'b1, 8'h1B);
    idle_chk(20, "to20", ex(P_NO, 3'd4, 0), ex(P_NO, 3'd4, 0));
    send(1'b1, 8'h41);
    chk("to20_a", out_a, ex(P_NO, 3'd4, 1));
    chk("to20_b", out_b, ex(P_LF, 3'd3, 0));

    // Timeout boundary: after 15 idle cycles the counter sits at 15 and a
    // byte still wins; after 16 idle cycles the sequence is gone.
    send(1'b1, 8'h1B);
    idle_chk(15, "b15", ex(P_NO, 3'd4, 0), ex(P_NO, 3'd3, 0));
    send(1'b1, 8'h41);
    chk("b15_a", out_a, ex(P_NO, 3'd4, 1));
    chk("b15_b", out_b, ex(P_NO, 3'd3, 1));

    send(1'b1, 8'h1B);
    idle_chk(16, "b16", ex(P_NO, 3'd4, 0), ex(P_NO, 3'd3, 0));
    send(1'b1, 8'h41);
    chk("b16_a", out_a, ex(P_NO, 3'd4, 1));
    chk("b16_b", out_b, ex(P_LF, 3'd3, 0));

    // '[' lands exactly in the timeout cycle: CSI is entered.
    send(1'b1, 8'h1B);
    idle_chk(15, "tie", ex(P_NO, 3'd4, 0), ex(P_NO, 3'd3, 0));
    send(1'b1, 8'h5B);
    chk("tie_csi_a", out_a, ex(P_NO, 3'd4, 0));
    chk("tie_csi_b", out_b, ex(P_NO, 3'd3, 0));
    send(1'b1, 8'h41);
    chk("tie_up_a", out_a, ex(P_UP, 3'd1, 0));
    chk("tie_up_b", out_b, ex(P_UP, 3'd1, 0));

    // Reset in the middle of a CSI sequence.
    send(1'b1, 8'h1B);
    send(1'b1, 8'h5B);
    chk("rst_pre_a", out_a, ex(P_NO, 3'd1, 0));
    chk("rst_pre_b", out_b, ex(P_NO, 3'd1, 0));
    reset    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    #1;
    chk("rst_async_a", out_a, '0);
    chk("rst_async_b", out_b, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_hold%0d_a", i), out_a, '0);
      chk($sformatf("rst_hold%0d_b", i), out_b, '0);
    end
    reset = 1'b1;
    send(1'b1, 8'h42);
    chk("rst_post42_a", out_a, '0);
    chk("rst_post42_b", out_b, '0);
    send(1'b1, 8'h77);
    chk("rst_post77_a", out_a, ex(P_UP, 3'd1, 0));
    chk("rst_post77_b", out_b, ex(P_UP, 3'd1, 0));
    send(1'b0, 8'h00);
    chk("rst_tail_a", out_a, ex(P_NO, 3'd1, 0));
    chk("rst_tail_b", out_b, ex(P_NO, 3'd1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
